// File: rtl/ifmap_row_loader.sv
// Streams IFMap rows from SRAM into the PE circular buffer, tagging each word with row-framing flags.
// Optional zero padding around each row is built when IFMAP_ROW_LOADER_PAD_EN is defined.
module ifmap_row_loader #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 5,
    parameter int ROWS_WIDTH = 5,
    parameter int PAD_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] row_stride,
    input  logic [LEN_WIDTH-1:0]  row_len,
    input  logic [ROWS_WIDTH-1:0] num_rows,
    input  logic [PAD_WIDTH-1:0]  pad_size,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  buf_ready,
    output logic                  buf_wen,
    output logic [DATA_WIDTH+1:0] buf_din,
    output logic                  pe_start,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {IDLE, PAD_PRE, READ, PAD_POST, FINISH} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [ROWS_WIDTH-1:0] rows_q;
    logic [LEN_WIDTH-1:0]  rd_cnt;
    logic [LEN_WIDTH-1:0]  wr_cnt;
    logic [ROWS_WIDTH-1:0] row_idx;
    logic                  pend;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  pad_on;
    logic                  wr_last;
    logic                  row_last;
    logic [1:0]            flags;
    logic [DATA_WIDTH-1:0] wdata;

`ifdef IFMAP_ROW_LOADER_PAD_EN
    logic [PAD_WIDTH-1:0]  pad_q;
    logic [PAD_WIDTH-1:0]  pad_cnt;
    logic                  pad_last;
    assign pad_on   = (pad_q != '0);
    assign pad_last = (pad_cnt == pad_q - 1'b1);
`else
    logic unused_pad;
    assign pad_on     = 1'b0;
    assign unused_pad = ^pad_size;
`endif

    assign wr_last  = (wr_cnt == len_q - 1'b1);
    assign row_last = (row_idx == rows_q - 1'b1);
    assign busy     = (state != IDLE);

    // Writes come from the skid register when it holds data, else straight from the SRAM read port.
    always_comb begin
        mem_ren  = 1'b0;
        mem_addr = '0;
        buf_wen  = 1'b0;
        flags    = 2'b00;
        wdata    = '0;
        case (state)
            READ: begin
                mem_ren = buf_ready && !skid_valid && (rd_cnt != len_q);
                if (mem_ren) mem_addr = row_base + ADDR_WIDTH'(rd_cnt);
                buf_wen = (skid_valid || pend) && buf_ready;
                wdata   = skid_valid ? skid_data : mem_rdata;
                flags   = {!pad_on && (wr_cnt == '0), !pad_on && wr_last};
            end
`ifdef IFMAP_ROW_LOADER_PAD_EN
            PAD_PRE: begin
                buf_wen = buf_ready;
                flags   = {pad_cnt == '0, 1'b0};
            end
            PAD_POST: begin
                buf_wen = buf_ready;
                flags   = {1'b0, pad_last};
            end
`endif
            default: ;
        endcase
        buf_din = buf_wen ? {flags, wdata} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row_base   <= '0;
            stride_q   <= '0;
            len_q      <= '0;
            rows_q     <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            row_idx    <= '0;
            pend       <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            pe_start   <= 1'b0;
            done       <= 1'b0;
`ifdef IFMAP_ROW_LOADER_PAD_EN
            pad_q      <= '0;
            pad_cnt    <= '0;
`endif
        end else begin
            pend     <= 1'b0;
            pe_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        row_base <= base_addr;
                        stride_q <= row_stride;
                        len_q    <= row_len;
                        rows_q   <= num_rows;
                        rd_cnt   <= '0;
                        wr_cnt   <= '0;
                        row_idx  <= '0;
`ifdef IFMAP_ROW_LOADER_PAD_EN
                        pad_q    <= pad_size;
                        pad_cnt  <= '0;
`endif
                        if (row_len == '0 || num_rows == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
`ifdef IFMAP_ROW_LOADER_PAD_EN
                        end else if (pad_size != '0) begin
                            state <= PAD_PRE;
`endif
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    pend <= mem_ren;
                    if (mem_ren) rd_cnt <= rd_cnt + 1'b1;
                    if (buf_wen) begin
                        skid_valid <= 1'b0;
                        wr_cnt     <= wr_cnt + 1'b1;
                        if (wr_last) begin
                            if (pad_on) begin
                                state <= PAD_POST;
                            end else begin
                                pe_start <= (row_idx == '0);
                                if (row_last) begin
                                    state <= FINISH;
                                    done  <= 1'b1;
                                end else begin
                                    row_idx  <= row_idx + 1'b1;
                                    row_base <= row_base + stride_q;
                                    rd_cnt   <= '0;
                                    wr_cnt   <= '0;
                                end
                            end
                        end
                    end else if (pend) begin
                        skid_valid <= 1'b1;
                        skid_data  <= mem_rdata;
                    end
                end
`ifdef IFMAP_ROW_LOADER_PAD_EN
                PAD_PRE: begin
                    if (buf_ready) begin
                        if (pad_last) begin
                            pad_cnt <= '0;
                            state   <= READ;
                        end else begin
                            pad_cnt <= pad_cnt + 1'b1;
                        end
                    end
                end
                PAD_POST: begin
                    if (buf_ready) begin
                        if (pad_last) begin
                            pad_cnt  <= '0;
                            pe_start <= (row_idx == '0);
                            if (row_last) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                row_idx  <= row_idx + 1'b1;
                                row_base <= row_base + stride_q;
                                rd_cnt   <= '0;
                                wr_cnt   <= '0;
                                state    <= PAD_PRE;
                            end
                        end else begin
                            pad_cnt <= pad_cnt + 1'b1;
                        end
                    end
                end
`endif
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifmap_row_loader.sv
// Scoreboard bench for ifmap_row_loader: expected buffer words and read addresses are queued per job
// and a negedge monitor compares them whenever the DUT writes or reads.
module tb_ifmap_row_loader;

`ifdef IFMAP_ROW_LOADER_PAD_EN
    localparam bit PADON = 1'b1;
`else
    localparam bit PADON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [9:0]  row_stride = '0;
    logic [4:0]  row_len = '0;
    logic [4:0]  num_rows = '0;
    logic [1:0]  pad_size = '0;
    logic        buf_ready = 1'b1;
    logic [9:0]  mem_rdata;
    logic        mem_ren;
    logic [9:0]  mem_addr;
    logic        buf_wen;
    logic [11:0] buf_din;
    logic        pe_start;
    logic        busy;
    logic        done;

    logic [9:0]  mem [0:1023];
    logic [11:0] wq [$];
    logic [9:0]  aq [$];
    logic [11:0] exp_w;
    logic [9:0]  exp_a;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wen_cnt, pe_cnt, done_cnt, row0_end, first_wen, last_wen, done_cyc, pe_cyc, e0;
    int j_len, j_rows;
    bit j_pad, j_deg;
    int o_cnt = 0;
    int o_new;

    ifmap_row_loader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_stride(row_stride),
        .row_len(row_len), .num_rows(num_rows), .pad_size(pad_size), .mem_ren(mem_ren),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .buf_ready(buf_ready), .buf_wen(buf_wen),
        .buf_din(buf_din), .pe_start(pe_start), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic pw(input logic [1:0] f, input logic [9:0] d);
        wq.push_back({f, d});
    endtask

    task automatic pa(input int a);
        aq.push_back(10'(a));
    endtask

    always @(negedge clk) begin
        if (buf_wen) begin
            wen_cnt++;
            last_wen = cyc;
            if (first_wen < 0) first_wen = cyc;
            chk("wen_with_ready", buf_ready, 1);
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h want none", buf_din);
            end else begin
                exp_w = wq.pop_front();
                chk("write_word", buf_din, exp_w);
            end
            if (buf_din[10] && row0_end < 0) row0_end = cyc;
        end
        if (mem_ren) begin
            if (aq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %0h want none", mem_addr);
            end else begin
                exp_a = aq.pop_front();
                chk("read_addr", mem_addr, exp_a);
            end
        end
        o_new = o_cnt + (mem_ren ? 1 : 0) - (buf_wen ? 1 : 0);
        if (mem_ren) chk("outstanding_le1", (o_new <= 1) ? 1 : 0, 1);
        o_cnt = rst ? 0 : o_new;
        if (pe_start) begin pe_cnt++; pe_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
    end

    task automatic begin_job(input int b, input int s, input int l, input int r, input int p);
        wen_cnt = 0; pe_cnt = 0; done_cnt = 0; row0_end = -1;
        first_wen = -1; last_wen = -1; done_cyc = -1; pe_cyc = -1;
        j_len = l; j_rows = r; j_pad = PADON && (p != 0); j_deg = (l == 0) || (r == 0);
        base_addr = 10'(b); row_stride = 10'(s); row_len = 5'(l); num_rows = 5'(r);
        pad_size = 2'(p); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e0 = cyc;
        @(negedge clk);
        chk("busy_rise", busy, 1);
        if (!j_deg && !j_pad) chk("first_ren", mem_ren, 1);
    endtask

    task automatic stall_after3();
        int n = 0;
        while (wen_cnt < 3 && n < 100) begin @(posedge clk); n++; end
        chk("bp_reached_3_writes", (wen_cnt >= 3) ? 1 : 0, 1);
        #1 buf_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 buf_ready = 1'b1;
    endtask

    task automatic finish_job(input int exp_pe, input bit bp);
        int n = 0;
        while (done_cnt == 0 && n < 400) begin @(posedge clk); n++; end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done want done within 400 cycles");
        end else if (j_deg) begin
            chk("deg_done_cycle", done_cyc, e0);
            chk("deg_writes", wen_cnt, 0);
        end else begin
            chk("first_wen_latency", first_wen, j_pad ? e0 : e0 + 1);
            if (!j_pad && !bp) chk("done_after_last_wen", done_cyc, last_wen + 1);
            if (!j_pad && !bp && j_rows == 1) chk("throughput", last_wen - first_wen, j_len - 1);
        end
        chk("pe_count", pe_cnt, exp_pe);
        if (exp_pe > 0) chk("pe_timing", pe_cyc, row0_end + 1);
        chk("words_drained", wq.size(), 0);
        chk("reads_drained", aq.size(), 0);
        @(negedge clk);
        chk("busy_fall", busy, 0);
    endtask

    task automatic push_row8();
        pw(2'b10, 1); pw(2'b00, 2); pw(2'b00, 3); pw(2'b00, 4);
        pw(2'b00, 3); pw(2'b00, 2); pw(2'b00, 1); pw(2'b01, 0);
        for (int i = 0; i < 8; i++) pa(i);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
        mem[4] = 3; mem[5] = 2; mem[6] = 1; mem[7] = 0;
        mem[8] = 21; mem[9] = 22; mem[10] = 23; mem[11] = 24;
        mem[32] = 5; mem[33] = 6; mem[34] = 7;
        mem[40] = 9; mem[1022] = 11; mem[1023] = 12;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
        chk("rst_pe_start", pe_start, 0); chk("rst_mem_ren", mem_ren, 0);
        chk("rst_buf_wen", buf_wen, 0); chk("rst_buf_din", buf_din, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single 8-word row
        push_row8();
        begin_job(0, 0, 8, 1, 0);
        finish_job(1, 0);

        // same row with a 3-cycle stall after the third write
        push_row8();
        begin_job(0, 0, 8, 1, 0);
        stall_after3();
        finish_job(1, 1);

        // two rows with stride 8; a start mid-job must be dropped
        pw(2'b10, 1); pw(2'b00, 2); pw(2'b00, 3); pw(2'b01, 4);
        pw(2'b10, 21); pw(2'b00, 22); pw(2'b00, 23); pw(2'b01, 24);
        for (int i = 0; i < 4; i++) pa(i);
        for (int i = 8; i < 12; i++) pa(i);
        begin_job(0, 8, 4, 2, 0);
        @(posedge clk);
        #1 base_addr = 10'd500; row_len = 5'd1; num_rows = 5'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_job(1, 0);

        // single-word row
        pw(2'b11, 9); pa(40);
        begin_job(40, 0, 1, 1, 0);
        finish_job(1, 0);

        // degenerate jobs
        begin_job(0, 0, 0, 1, 0);
        finish_job(0, 0);
        begin_job(0, 0, 4, 0, 0);
        finish_job(0, 0);

        // address wrap past the top of memory
        pw(2'b10, 11); pw(2'b00, 12); pw(2'b00, 1); pw(2'b01, 2);
        pa(1022); pa(1023); pa(0); pa(1);
        begin_job(1022, 0, 4, 1, 0);
        finish_job(1, 0);

        // reset after the second write, then replay the row
        push_row8();
        begin_job(0, 0, 8, 1, 0);
        begin
            int n = 0;
            while (wen_cnt < 2 && n < 100) begin @(posedge clk); n++; end
        end
        chk("rst_mid_reached", (wen_cnt >= 2) ? 1 : 0, 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);      chk("mid_rst_done", done, 0);
        chk("mid_rst_pe_start", pe_start, 0); chk("mid_rst_mem_ren", mem_ren, 0);
        chk("mid_rst_mem_addr", mem_addr, 0); chk("mid_rst_buf_wen", buf_wen, 0);
        chk("mid_rst_buf_din", buf_din, 0);
        wq.delete();
        aq.delete();
        push_row8();
        begin_job(0, 0, 8, 1, 0);
        finish_job(1, 0);

        // padding: one zero word each side when built in, ignored otherwise
`ifdef IFMAP_ROW_LOADER_PAD_EN
        pw(2'b10, 0); pw(2'b00, 5); pw(2'b00, 6); pw(2'b00, 7); pw(2'b01, 0);
`else
        pw(2'b10, 5); pw(2'b00, 6); pw(2'b01, 7);
`endif
        pa(32); pa(33); pa(34);
        begin_job(32, 0, 3, 1, 1);
        finish_job(1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
